// File: rtl/id_stage_pipe_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for id_stage_pipe.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic            flush;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ex_rd_wen;
  logic [4:0]      ex_rd_addr;
  logic [XLEN-1:0] ex_rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [3:0]      alu_op;
  logic [4:0]      rd_addr;
  logic            rd_wen;
  logic            illegal;

  modport slave (
    input  in_valid, inst, flush, rs1_data, rs2_data,
           ex_rd_wen, ex_rd_addr, ex_rd_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid,
           op1, op2, alu_op, rd_addr, rd_wen, illegal
  );

  modport master (
    output in_valid, inst, flush, rs1_data, rs2_data,
           ex_rd_wen, ex_rd_addr, ex_rd_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid,
           op1, op2, alu_op, rd_addr, rd_wen, illegal
  );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I decode stage for OP-IMM, OP and LUI with EX bypass and an ID/EX
// register under a valid/ready handshake, flush and asynchronous reset.
module id_stage_pipe #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  id_stage_pipe_if.slave bus
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic            is_op_imm, is_op, is_lui;
  logic [4:0]      rs1_sel, rs2_sel;
  logic [XLEN-1:0] src1, src2;
  logic [XLEN-1:0] imm_i, imm_u, shamt;
  logic [XLEN-1:0] op1_d, op2_d;
  logic [3:0]      alu_d;
  logic            illegal_d, rd_wen_d;
  logic            accept;

  logic            out_valid_q;
  logic [XLEN-1:0] op1_q, op2_q;
  logic [3:0]      alu_q;
  logic [4:0]      rd_q;
  logic            rd_wen_q, illegal_q;

  assign opcode    = bus.inst[6:0];
  assign funct3    = bus.inst[14:12];
  assign funct7    = bus.inst[31:25];
  assign rd        = bus.inst[11:7];
  assign is_op_imm = (opcode == OPC_OP_IMM);
  assign is_op     = (opcode == OPC_OP);
  assign is_lui    = (opcode == OPC_LUI);

  // Unused sources read as x0 so they can never match the bypass address.
  assign rs1_sel = (is_op_imm || is_op) ? bus.inst[19:15] : 5'd0;
  assign rs2_sel = is_op ? bus.inst[24:20] : 5'd0;
  assign bus.rs1_addr = rs1_sel;
  assign bus.rs2_addr = rs2_sel;

  assign src1 = (FWD_EN && bus.ex_rd_wen && (bus.ex_rd_addr != 5'd0) && (bus.ex_rd_addr == rs1_sel))
                ? bus.ex_rd_data : bus.rs1_data;
  assign src2 = (FWD_EN && bus.ex_rd_wen && (bus.ex_rd_addr != 5'd0) && (bus.ex_rd_addr == rs2_sel))
                ? bus.ex_rd_data : bus.rs2_data;

  always_comb begin
    imm_i        = {XLEN{bus.inst[31]}};
    imm_i[11:0]  = bus.inst[31:20];
    imm_u        = {XLEN{bus.inst[31]}};
    imm_u[31:0]  = {bus.inst[31:12], 12'b0};
    shamt        = '0;
    shamt[4:0]   = bus.inst[24:20];
  end

  always_comb begin
    illegal_d = 1'b0;
    alu_d     = ALU_ADD;
    op1_d     = '0;
    op2_d     = '0;
    case (opcode)
      OPC_OP_IMM: begin
        op1_d = src1;
        op2_d = imm_i;
        case (funct3)
          3'b000: alu_d = ALU_ADD;
          3'b001: begin
            alu_d = ALU_SLL;
            op2_d = shamt;
            if (funct7 != F7_ZERO) illegal_d = 1'b1;
          end
          3'b010: alu_d = ALU_SLT;
          3'b011: alu_d = ALU_SLTU;
          3'b100: alu_d = ALU_XOR;
          3'b101: begin
            op2_d = shamt;
            if (funct7 == F7_ZERO)     alu_d = ALU_SRL;
            else if (funct7 == F7_ALT) alu_d = ALU_SRA;
            else                       illegal_d = 1'b1;
          end
          3'b110: alu_d = ALU_OR;
          default: alu_d = ALU_AND;
        endcase
      end
      OPC_OP: begin
        op1_d = src1;
        op2_d = src2;
        case (funct3)
          3'b000: alu_d = ALU_ADD;
          3'b001: alu_d = ALU_SLL;
          3'b010: alu_d = ALU_SLT;
          3'b011: alu_d = ALU_SLTU;
          3'b100: alu_d = ALU_XOR;
          3'b101: alu_d = ALU_SRL;
          3'b110: alu_d = ALU_OR;
          default: alu_d = ALU_AND;
        endcase
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      alu_d = ALU_SUB;
          else if (funct3 == 3'b101) alu_d = ALU_SRA;
          else                       illegal_d = 1'b1;
        end else if (funct7 != F7_ZERO) begin
          illegal_d = 1'b1;
        end
      end
      OPC_LUI: op2_d = imm_u;
      default: illegal_d = 1'b1;
    endcase
    // Illegal instructions carry a neutral payload to the trap logic.
    if (illegal_d) begin
      op1_d = '0;
      op2_d = '0;
      alu_d = ALU_ADD;
    end
  end

  assign rd_wen_d     = !illegal_d && (rd != 5'd0);
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_q       <= ALU_ADD;
      rd_q        <= 5'd0;
      rd_wen_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_q       <= alu_d;
      rd_q        <= rd;
      rd_wen_q    <= rd_wen_d;
      illegal_q   <= illegal_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.alu_op    = alu_q;
  assign bus.rd_addr   = rd_q;
  assign bus.rd_wen    = rd_wen_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: expected ID/EX contents are queued at issue
// and popped when the stage presents them; a FWD_EN=0 twin checks the no-bypass path.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.XLEN(32)) ifc ();
  id_stage_pipe_if #(.XLEN(32)) ifc0 ();

  id_stage_pipe #(.XLEN(32), .FWD_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(ifc));
  id_stage_pipe #(.XLEN(32), .FWD_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));

  assign ifc0.in_valid   = ifc.in_valid;
  assign ifc0.inst       = ifc.inst;
  assign ifc0.flush      = ifc.flush;
  assign ifc0.rs1_data   = ifc.rs1_data;
  assign ifc0.rs2_data   = ifc.rs2_data;
  assign ifc0.ex_rd_wen  = ifc.ex_rd_wen;
  assign ifc0.ex_rd_addr = ifc.ex_rd_addr;
  assign ifc0.ex_rd_data = ifc.ex_rd_data;
  assign ifc0.out_ready  = ifc.out_ready;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  function automatic exp_t mk(logic [31:0] op1, logic [31:0] op2, logic [3:0] alu,
                              logic [4:0] rd, logic wen, logic ill);
    exp_t e;
    e.op1 = op1; e.op2 = op2; e.alu = alu; e.rd = rd; e.wen = wen; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, ".op1"},     ifc.op1,     e.op1);
    chk({tag, ".op2"},     ifc.op2,     e.op2);
    chk({tag, ".alu_op"},  ifc.alu_op,  32'(e.alu));
    chk({tag, ".rd_addr"}, ifc.rd_addr, 32'(e.rd));
    chk({tag, ".rd_wen"},  ifc.rd_wen,  32'(e.wen));
    chk({tag, ".illegal"}, ifc.illegal, 32'(e.ill));
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] d1, input logic [31:0] d2,
                       input exp_t e);
    int k;
    k = 0;
    ifc.inst     = i;
    ifc.rs1_data = d1;
    ifc.rs2_data = d2;
    ifc.in_valid = 1'b1;
    #1;
    while (!ifc.in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("issue_in_ready", ifc.in_ready, 1);
    sb.push_back(e);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, ".out_valid"}, ifc.out_valid, 1);
    chk({tag, ".sb_size"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_fields(tag, e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    rst            = 1'b1;
    ifc.in_valid   = 1'b0;
    ifc.inst       = 32'h0;
    ifc.flush      = 1'b0;
    ifc.rs1_data   = 32'h0;
    ifc.rs2_data   = 32'h0;
    ifc.ex_rd_wen  = 1'b0;
    ifc.ex_rd_addr = 5'd0;
    ifc.ex_rd_data = 32'h0;
    ifc.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", ifc.out_valid, 0);
    chk_fields("reset", mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0));
    rst = 1'b0;
    idle();

    // ADDI x1,x0,-1
    issue(32'hFFF00093, 32'h0, 32'h0, mk(32'h0, 32'hFFFF_FFFF, 4'd0, 5'd1, 1'b1, 1'b0));
    check_out("addi_neg");
    idle();
    chk("drain.out_valid", ifc.out_valid, 0);

    // SUB x3,x1,x2 with x2 bypassed from EX
    ifc.ex_rd_wen = 1'b1; ifc.ex_rd_addr = 5'd2; ifc.ex_rd_data = 32'd7;
    issue(32'h402081B3, 32'd10, 32'd5, mk(32'd10, 32'd7, 4'd1, 5'd3, 1'b1, 1'b0));
    chk("sub_nofwd.op2", ifc0.op2, 32'd5);
    chk("sub_nofwd.op1", ifc0.op1, 32'd10);
    check_out("sub_fwd");

    // ADD x4,x0,x0 with EX writing x0: no bypass
    ifc.ex_rd_addr = 5'd0; ifc.ex_rd_data = 32'h55;
    issue(32'h00000233, 32'h0, 32'h0, mk(32'h0, 32'h0, 4'd0, 5'd4, 1'b1, 1'b0));
    check_out("add_x0_nofwd");

    // ADDI x6,x1,3: EX targets x3 (== inst[24:20]) but OP-IMM has no rs2
    ifc.ex_rd_addr = 5'd3; ifc.ex_rd_data = 32'hDEAD;
    issue(32'h00308313, 32'h100, 32'h999, mk(32'h100, 32'd3, 4'd0, 5'd6, 1'b1, 1'b0));
    chk("addi.rs1_addr", ifc.rs1_addr, 1);
    chk("addi.rs2_addr", ifc.rs2_addr, 0);
    check_out("addi_imm");

    // XORI x7,x1,-2 with x1 bypassed
    ifc.ex_rd_addr = 5'd1; ifc.ex_rd_data = 32'h77;
    issue(32'hFFE0C393, 32'h11, 32'h0, mk(32'h77, 32'hFFFF_FFFE, 4'd5, 5'd7, 1'b1, 1'b0));
    check_out("xori_fwd");
    ifc.ex_rd_wen = 1'b0;

    // SRAI x8,x9,31
    issue(32'h41F4D413, 32'h8000_0000, 32'h0, mk(32'h8000_0000, 32'h1F, 4'd7, 5'd8, 1'b1, 1'b0));
    check_out("srai");

    // SLLI with funct7=0100000 is illegal
    issue(32'h40109093, 32'h1234, 32'h0, mk(32'h0, 32'h0, 4'd0, 5'd1, 1'b0, 1'b1));
    check_out("slli_bad_f7");

    // SLTU x10,x11,x12
    issue(32'h00C5B533, 32'hAAAA, 32'hBBBB, mk(32'hAAAA, 32'hBBBB, 4'd4, 5'd10, 1'b1, 1'b0));
    chk("sltu.rs2_addr", ifc.rs2_addr, 12);
    check_out("sltu");

    // Unknown opcode 0x7F
    issue(32'h0000007F, 32'h5, 32'h6, mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1));
    check_out("bad_opcode");

    // ADD with funct7=0000001
    issue(32'h02208233, 32'h5, 32'h6, mk(32'h0, 32'h0, 4'd0, 5'd4, 1'b0, 1'b1));
    check_out("add_f7_1");

    // ADDI x0,x1,5
    issue(32'h00508013, 32'h20, 32'h0, mk(32'h20, 32'd5, 4'd0, 5'd0, 1'b0, 1'b0));
    check_out("addi_rd0");

    // LUI x5,0x12345
    issue(32'h123452B7, 32'hFFFF, 32'hFFFF, mk(32'h0, 32'h1234_5000, 4'd0, 5'd5, 1'b1, 1'b0));
    chk("lui.rs1_addr", ifc.rs1_addr, 0);
    chk("lui.rs2_addr", ifc.rs2_addr, 0);
    check_out("lui");
    idle();

    // Stall: OR held for 3 cycles while AND waits
    ifc.out_ready = 1'b0;
    issue(32'h00F766B3, 32'hF0F0, 32'h0FF0, mk(32'hF0F0, 32'h0FF0, 4'd8, 5'd13, 1'b1, 1'b0));
    ifc.inst = 32'h0128F833; ifc.rs1_data = 32'hFF00; ifc.rs2_data = 32'h0F0F;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.in_ready", ifc.in_ready, 0);
      chk("stall.out_valid", ifc.out_valid, 1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk_fields("stall_hold", e);
      end
      @(posedge clk); #0;
    end
    #1;
    ifc.out_ready = 1'b1;
    #1;
    chk("stall_release.in_ready", ifc.in_ready, 1);
    check_out("stall_first");
    sb.push_back(mk(32'hFF00, 32'h0F0F, 4'd9, 5'd16, 1'b1, 1'b0));
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    check_out("stall_second");

    // Flush with an incoming instruction
    ifc.flush = 1'b1; ifc.in_valid = 1'b1; ifc.inst = 32'h00508013;
    idle();
    chk("flush.out_valid", ifc.out_valid, 0);
    ifc.flush = 1'b0; ifc.in_valid = 1'b0;
    issue(32'hFFF00093, 32'h0, 32'h0, mk(32'h0, 32'hFFFF_FFFF, 4'd0, 5'd1, 1'b1, 1'b0));
    check_out("post_flush");
    idle();

    // Asynchronous reset during a stall
    ifc.out_ready = 1'b0;
    issue(32'h123452B7, 32'h0, 32'h0, mk(32'h0, 32'h1234_5000, 4'd0, 5'd5, 1'b1, 1'b0));
    check_out("pre_reset_lui");
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.out_valid", ifc.out_valid, 0);
    chk("async_rst.rd_wen", ifc.rd_wen, 0);
    chk("async_rst.op2", ifc.op2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    idle();
    chk("post_rst.out_valid", ifc.out_valid, 0);
    chk("final.sb_size", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
